// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU arbiter: opcodes, FSM encoding,
// shift-amount width and a small one-hot helper.
package alu_pkg;

    // 3-bit ALU opcodes
    localparam logic [2:0] ALU_OP_AND = 3'b000;
    localparam logic [2:0] ALU_OP_OR  = 3'b001;
    localparam logic [2:0] ALU_OP_XOR = 3'b010;
    localparam logic [2:0] ALU_OP_ADD = 3'b011;
    localparam logic [2:0] ALU_OP_SUB = 3'b100;
    localparam logic [2:0] ALU_OP_SLT = 3'b101;
    localparam logic [2:0] ALU_OP_SLL = 3'b110;
    localparam logic [2:0] ALU_OP_SRL = 3'b111;

    // Number of low-order operand B bits that form a legal shift amount
    localparam int ALU_SHAMT_W = 5;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } arb_state_t;

    // Requester id -> per-requester one-hot vector (bit 0 = requester 0)
    function automatic logic [1:0] grant_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the two ALU requesters and the shared
// arbiter. Operand and result buses use [0:WIDTH-1] ordering (bit 0 = MSB);
// per-requester vectors use bit 0 for requester 0.
interface alu_share_arb_if #(
    parameter int WIDTH = 32
);

    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [2:0]       req_op0;
    logic [2:0]       req_op1;
    logic [0:WIDTH-1] req_a0;
    logic [0:WIDTH-1] req_a1;
    logic [0:WIDTH-1] req_b0;
    logic [0:WIDTH-1] req_b1;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [0:WIDTH-1] rsp_data;
    logic             rsp_err;

    // Requester side: issues operations and accepts responses
    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    // Arbiter side: grants requests and returns results
    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/alu_op_unit.sv
// Combinational ALU slice: AND/OR/XOR/ADD/SUB/SLT/SLL/SRL on [0:WIDTH-1]
// operands. Shifts use the low ALU_SHAMT_W bits of B; any higher B bit set
// means an out-of-range shift, which yields result 0 and err 1.
module alu_op_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [0:WIDTH-1] a,
    input  logic [0:WIDTH-1] b,
    output logic [0:WIDTH-1] result,
    output logic             err
);

    logic [ALU_SHAMT_W-1:0] shamt;
    logic                   shift_oob;
    logic [0:WIDTH-1]       and_res;
    logic [0:WIDTH-1]       or_res;
    logic [0:WIDTH-1]       xor_res;
    logic [0:WIDTH-1]       add_res;
    logic [0:WIDTH-1]       sub_res;
    logic [0:WIDTH-1]       slt_res;
    logic [0:WIDTH-1]       sll_res;
    logic [0:WIDTH-1]       srl_res;

    assign shamt     = b[WIDTH-ALU_SHAMT_W:WIDTH-1];
    assign shift_oob = |b[0:WIDTH-ALU_SHAMT_W-1];

    assign and_res = a & b;
    assign or_res  = a | b;
    assign xor_res = a ^ b;
    assign add_res = a + b;
    assign sub_res = a - b;
    assign slt_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
    assign sll_res = a << shamt;
    assign srl_res = a >> shamt;

    // Select the requested op; out-of-range shifts flag an error and return zero
    always_comb begin
        result = '0;
        err    = 1'b0;
        case (op)
            ALU_OP_AND: result = and_res;
            ALU_OP_OR:  result = or_res;
            ALU_OP_XOR: result = xor_res;
            ALU_OP_ADD: result = add_res;
            ALU_OP_SUB: result = sub_res;
            ALU_OP_SLT: result = slt_res;
            ALU_OP_SLL: begin
                if (shift_oob) begin
                    err = 1'b1;
                end else begin
                    result = sll_res;
                end
            end
            ALU_OP_SRL: begin
                if (shift_oob) begin
                    err = 1'b1;
                end else begin
                    result = srl_res;
                end
            end
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin arbiter sharing one ALU between requester 0 (execute stage)
// and requester 1 (address/branch unit). One op in flight: IDLE accepts and
// latches operands, EXEC registers the result, RESP holds it until the
// granted requester accepts.
// Optional build macro ALU_ARB_PERF_EN adds saturating grant/stall counters;
// without it the perf_* outputs are constant zero.
module alu_share_arb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    alu_share_arb_if.slave   bus,
    output logic [CNT_W-1:0] perf_grant0,
    output logic [CNT_W-1:0] perf_grant1,
    output logic [CNT_W-1:0] perf_stall
);

    arb_state_t       state;
    arb_state_t       state_next;
    logic             prio;
    logic             grant_id;
    logic [2:0]       op_q;
    logic [0:WIDTH-1] a_q;
    logic [0:WIDTH-1] b_q;
    logic [0:WIDTH-1] rsp_data_q;
    logic             rsp_err_q;
    logic [1:0]       ready_c;
    logic             handshake;
    logic             sel;
    logic [0:WIDTH-1] alu_result;
    logic             alu_err;

    // Offer ready only while idle: a lone valid requester wins, a tie goes to prio
    always_comb begin
        ready_c = 2'b00;
        if (state == S_IDLE && !reset) begin
            case (bus.req_valid)
                2'b01:   ready_c = 2'b01;
                2'b10:   ready_c = 2'b10;
                2'b11:   ready_c = grant_onehot(prio);
                default: ready_c = 2'b00;
            endcase
        end
    end

    // ready is only ever raised towards a valid requester, so any ready is a handshake
    assign handshake     = |ready_c;
    assign sel           = ready_c[1];
    assign bus.req_ready = ready_c;

    // Next-state logic: accept -> compute -> hold response until the granted side takes it
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (handshake) begin
                    state_next = S_EXEC;
                end
            end
            S_EXEC: state_next = S_RESP;
            S_RESP: begin
                if (bus.rsp_ready[grant_id]) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State register; reset abandons any op in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Latch the winner's operands and hand priority to the other requester
    always_ff @(posedge clk) begin
        if (reset) begin
            prio     <= 1'b0;
            grant_id <= 1'b0;
            op_q     <= 3'b000;
            a_q      <= '0;
            b_q      <= '0;
        end else if (handshake) begin
            grant_id <= sel;
            prio     <= ~sel;
            op_q     <= sel ? bus.req_op1 : bus.req_op0;
            a_q      <= sel ? bus.req_a1  : bus.req_a0;
            b_q      <= sel ? bus.req_b1  : bus.req_b0;
        end
    end

    alu_op_unit #(
        .WIDTH (WIDTH)
    ) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_result),
        .err    (alu_err)
    );

    // Register the ALU output once, so it stays stable for the whole response phase
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
        end else if (state == S_EXEC) begin
            rsp_data_q <= alu_result;
            rsp_err_q  <= alu_err;
        end
    end

    assign bus.rsp_valid = (state == S_RESP) ? grant_onehot(grant_id) : 2'b00;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;

`ifdef ALU_ARB_PERF_EN
    logic [CNT_W-1:0] grant0_q;
    logic [CNT_W-1:0] grant1_q;
    logic [CNT_W-1:0] stall_q;
    logic             stall_c;

    // A stall is any cycle where someone is asking and nobody is being accepted
    assign stall_c = (|bus.req_valid) && (ready_c == 2'b00);

    // Saturating grant and stall counters
    always_ff @(posedge clk) begin
        if (reset) begin
            grant0_q <= '0;
            grant1_q <= '0;
            stall_q  <= '0;
        end else begin
            if (handshake && !sel && (grant0_q != '1)) begin
                grant0_q <= grant0_q + CNT_W'(1);
            end
            if (handshake && sel && (grant1_q != '1)) begin
                grant1_q <= grant1_q + CNT_W'(1);
            end
            if (stall_c && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
        end
    end

    assign perf_grant0 = grant0_q;
    assign perf_grant1 = grant1_q;
    assign perf_stall  = stall_q;
`else
    assign perf_grant0 = '0;
    assign perf_grant1 = '0;
    assign perf_stall  = '0;
`endif

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios with literal
// expectations, then randomized traffic. A transaction-level model tracks
// what each output must be and is compared against the DUT every cycle.
module tb_alu_share_arb;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam int CNT_W = 16;

    logic             clk;
    logic             reset;
    logic [CNT_W-1:0] perf_grant0;
    logic [CNT_W-1:0] perf_grant1;
    logic [CNT_W-1:0] perf_stall;

    int total = 0;
    int bad   = 0;

    alu_share_arb_if #(.WIDTH(WIDTH)) bus ();

    alu_share_arb #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .perf_grant0 (perf_grant0),
        .perf_grant1 (perf_grant1),
        .perf_stall  (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    // Reference ALU written from the op table with plain arithmetic; returns {err, result}
    function automatic logic [32:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] r;
        logic        e;
        r = '0;
        e = 1'b0;
        case (op)
            ALU_OP_AND: r = a & b;
            ALU_OP_OR:  r = a | b;
            ALU_OP_XOR: r = a ^ b;
            ALU_OP_ADD: r = a + b;
            ALU_OP_SUB: r = a - b;
            ALU_OP_SLT: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_OP_SLL: if (b < 32) r = a << b; else e = 1'b1;
            ALU_OP_SRL: if (b < 32) r = a >> b; else e = 1'b1;
            default:    r = '0;
        endcase
        return {e, r};
    endfunction

    function automatic int sat_inc(input int x);
        return (x >= (1 << CNT_W) - 1) ? x : x + 1;
    endfunction

    // Model: one op in flight; m_age counts cycles since acceptance, response visible from age 2
    bit          model_on = 1'b0;
    bit          m_busy   = 1'b0;
    int          m_age    = 0;
    bit          m_prio   = 1'b0;
    bit          m_g      = 1'b0;
    logic [31:0] m_data   = '0;
    bit          m_err    = 1'b0;
    int          m_g0     = 0;
    int          m_g1     = 0;
    int          m_stall  = 0;

    always @(negedge clk) begin : model_cmp
        logic [1:0]  v;
        logic [1:0]  rr;
        logic [1:0]  exp_ready;
        logic [1:0]  exp_rsp;
        logic [32:0] res;
        bit          g;
        v  = bus.req_valid;
        rr = bus.rsp_ready;
        exp_ready = 2'b00;
        if (reset !== 1'b1 && !m_busy) begin
            if (v == 2'b11) exp_ready = m_prio ? 2'b10 : 2'b01;
            else            exp_ready = v;
        end
        exp_rsp = (m_busy && m_age >= 2) ? (m_g ? 2'b10 : 2'b01) : 2'b00;
        if (model_on) begin
            checkOutput("req_ready", bus.req_ready, exp_ready);
            checkOutput("rsp_valid", bus.rsp_valid, exp_rsp);
            if (exp_rsp != 2'b00) begin
                checkOutput("rsp_data", bus.rsp_data, m_data);
                checkOutput("rsp_err", bus.rsp_err, m_err);
            end
`ifdef ALU_ARB_PERF_EN
            checkOutput("perf_grant0", perf_grant0, m_g0);
            checkOutput("perf_grant1", perf_grant1, m_g1);
            checkOutput("perf_stall", perf_stall, m_stall);
`else
            checkOutput("perf_grant0", perf_grant0, 0);
            checkOutput("perf_grant1", perf_grant1, 0);
            checkOutput("perf_stall", perf_stall, 0);
`endif
        end
        if (reset === 1'b1) begin
            model_on = 1'b1;
            m_busy   = 1'b0;
            m_age    = 0;
            m_prio   = 1'b0;
            m_g0     = 0;
            m_g1     = 0;
            m_stall  = 0;
        end else if (model_on) begin
            if (v != 2'b00 && exp_ready == 2'b00) m_stall = sat_inc(m_stall);
            if (!m_busy) begin
                if (v != 2'b00) begin
                    g = (v == 2'b11) ? m_prio : v[1];
                    if (g) res = alu_ref(bus.req_op1, bus.req_a1, bus.req_b1);
                    else   res = alu_ref(bus.req_op0, bus.req_a0, bus.req_b0);
                    m_err  = res[32];
                    m_data = res[31:0];
                    m_g    = g;
                    m_prio = !g;
                    m_busy = 1'b1;
                    m_age  = 1;
                    if (g) m_g1 = sat_inc(m_g1);
                    else   m_g0 = sat_inc(m_g0);
                end
            end else if (m_age >= 2 && rr[m_g]) begin
                m_busy = 1'b0;
                m_age  = 0;
            end else begin
                m_age++;
            end
        end
    end

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive all requester-side inputs at once
    task automatic applyStimulus(input logic [1:0] valid,
                                 input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] b1,
                                 input logic [1:0] rready);
        bus.req_valid = valid;
        bus.req_op0   = op0;
        bus.req_a0    = a0;
        bus.req_b0    = b0;
        bus.req_op1   = op1;
        bus.req_a1    = a1;
        bus.req_b1    = b1;
        bus.rsp_ready = rready;
    endtask

    task automatic doReset();
        applyStimulus(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 2'b00);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // Let any op in flight complete with both sides accepting, then go quiet
    task automatic drain();
        applyStimulus(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 2'b11);
        repeat (5) tick();
        bus.rsp_ready = 2'b00;
        tick();
    endtask

    // One uncontended op from requester 'who' with literal expectations on timing and result
    task automatic singleOp(input string name, input bit who, input logic [2:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_data, input bit exp_err);
        logic [1:0] oh;
        oh = who ? 2'b10 : 2'b01;
        applyStimulus(oh, op, a, b, op, a, b, 2'b00);
        @(negedge clk);
        checkOutput({name, "_ready"}, bus.req_ready, oh);
        tick();
        applyStimulus(2'b00, op, a, b, op, a, b, 2'b00);
        @(negedge clk);
        checkOutput({name, "_exec_rsp"}, bus.rsp_valid, 2'b00);
        tick();
        @(negedge clk);
        checkOutput({name, "_rsp_valid"}, bus.rsp_valid, oh);
        checkOutput({name, "_data"}, bus.rsp_data, exp_data);
        checkOutput({name, "_err"}, bus.rsp_err, exp_err);
        tick();
        bus.rsp_ready = oh;
        tick();
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        checkOutput({name, "_done"}, bus.rsp_valid, 2'b00);
        tick();
    endtask

    initial begin : stimulus
        bit          pend0;
        bit          pend1;
        logic [2:0]  op0;
        logic [2:0]  op1;
        logic [31:0] a0;
        logic [31:0] b0;
        logic [31:0] a1;
        logic [31:0] b1;
        logic [1:0]  hs;

        reset = 1'b1;
        applyStimulus(2'b00, 3'd0, 32'd0, 32'd0, 3'd0, 32'd0, 32'd0, 2'b00);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        @(negedge clk);
        checkOutput("reset_ready", bus.req_ready, 2'b00);
        checkOutput("reset_rsp_valid", bus.rsp_valid, 2'b00);
        checkOutput("reset_rsp_data", bus.rsp_data, 32'h0);
        checkOutput("reset_rsp_err", bus.rsp_err, 1'b0);
        checkOutput("reset_perf_grant0", perf_grant0, 0);
        tick();

        // Single XOR from requester 0
        singleOp("xor", 1'b0, ALU_OP_XOR, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1'b0);

        // Contention straight after reset: req0 first, then req1, then req0 again
        doReset();
        applyStimulus(2'b11, ALU_OP_ADD, 32'd5, 32'd7, ALU_OP_SUB, 32'd3, 32'd5, 2'b11);
        @(negedge clk);
        checkOutput("alt_ready_first", bus.req_ready, 2'b01);
        tick();
        @(negedge clk);
        checkOutput("alt_ready_exec", bus.req_ready, 2'b00);
        tick();
        @(negedge clk);
        checkOutput("alt_rsp0_valid", bus.rsp_valid, 2'b01);
        checkOutput("alt_rsp0_data", bus.rsp_data, 32'd12);
        tick();
        @(negedge clk);
        checkOutput("alt_ready_second", bus.req_ready, 2'b10);
        tick();
        tick();
        @(negedge clk);
        checkOutput("alt_rsp1_valid", bus.rsp_valid, 2'b10);
        checkOutput("alt_rsp1_data", bus.rsp_data, 32'hFFFFFFFE);
        tick();
        @(negedge clk);
        checkOutput("alt_ready_third", bus.req_ready, 2'b01);
        tick();
        drain();

        // Response backpressure with req1 waiting and a stray rsp_ready for req1
        applyStimulus(2'b01, ALU_OP_AND, 32'h12345678, 32'h0F0F0F0F, ALU_OP_OR, 32'h00FF0000, 32'h000000FF, 2'b00);
        @(negedge clk);
        checkOutput("bp_ready0", bus.req_ready, 2'b01);
        tick();
        applyStimulus(2'b10, ALU_OP_AND, 32'h12345678, 32'h0F0F0F0F, ALU_OP_OR, 32'h00FF0000, 32'h000000FF, 2'b10);
        tick();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold_valid", bus.rsp_valid, 2'b01);
            checkOutput("bp_hold_data", bus.rsp_data, 32'h02040608);
            checkOutput("bp_hold_ready", bus.req_ready, 2'b00);
            tick();
        end
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
        @(negedge clk);
        checkOutput("bp_grant1", bus.req_ready, 2'b10);
        checkOutput("bp_rsp_dropped", bus.rsp_valid, 2'b00);
        tick();
        drain();

        // Signed compare and shift edge cases
        singleOp("slt_neg", 1'b0, ALU_OP_SLT, 32'h80000000, 32'd1, 32'd1, 1'b0);
        singleOp("slt_pos", 1'b1, ALU_OP_SLT, 32'd1, 32'h80000000, 32'd0, 1'b0);
        singleOp("sll31", 1'b0, ALU_OP_SLL, 32'd1, 32'd31, 32'h80000000, 1'b0);
        singleOp("srl32", 1'b1, ALU_OP_SRL, 32'hFFFFFFFF, 32'd32, 32'd0, 1'b1);
        singleOp("srl4", 1'b0, ALU_OP_SRL, 32'h80000000, 32'd4, 32'h08000000, 1'b0);

        // Reset during EXEC: no response, priority back to requester 0
        applyStimulus(2'b01, ALU_OP_ADD, 32'd1, 32'd1, ALU_OP_ADD, 32'd2, 32'd2, 2'b11);
        @(negedge clk);
        checkOutput("rst_accept", bus.req_ready, 2'b01);
        tick();
        applyStimulus(2'b00, ALU_OP_ADD, 32'd1, 32'd1, ALU_OP_ADD, 32'd2, 32'd2, 2'b11);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("rst_no_rsp", bus.rsp_valid, 2'b00);
        tick();
        applyStimulus(2'b11, ALU_OP_ADD, 32'd1, 32'd1, ALU_OP_ADD, 32'd2, 32'd2, 2'b11);
        @(negedge clk);
        checkOutput("rst_prio", bus.req_ready, 2'b01);
        checkOutput("rst_still_no_rsp", bus.rsp_valid, 2'b00);
        tick();
        drain();

        // Grant counters: three grants to req0, one to req1
        doReset();
        singleOp("perf_a", 1'b0, ALU_OP_OR, 32'd1, 32'd2, 32'd3, 1'b0);
        singleOp("perf_b", 1'b0, ALU_OP_ADD, 32'd10, 32'd20, 32'd30, 1'b0);
        singleOp("perf_c", 1'b1, ALU_OP_SUB, 32'd0, 32'd1, 32'hFFFFFFFF, 1'b0);
        singleOp("perf_d", 1'b0, ALU_OP_AND, 32'hFF, 32'h0F, 32'h0F, 1'b0);
        @(negedge clk);
`ifdef ALU_ARB_PERF_EN
        checkOutput("perf_grant0_lit", perf_grant0, 3);
        checkOutput("perf_grant1_lit", perf_grant1, 1);
`else
        checkOutput("perf_grant0_lit", perf_grant0, 0);
        checkOutput("perf_grant1_lit", perf_grant1, 0);
`endif
        checkOutput("perf_stall_lit", perf_stall, 0);
        tick();

        // Randomized traffic; requesters hold their request until it is accepted
        pend0 = 1'b0;
        pend1 = 1'b0;
        op0 = 3'd0; op1 = 3'd0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            hs = bus.req_valid & bus.req_ready;
            tick();
            if (hs[0]) pend0 = 1'b0;
            if (hs[1]) pend1 = 1'b0;
            if (!pend0 && $urandom_range(0, 2) != 0) begin
                pend0 = 1'b1;
                op0   = 3'($urandom_range(0, 7));
                a0    = $urandom;
                b0    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            end
            if (!pend1 && $urandom_range(0, 2) != 0) begin
                pend1 = 1'b1;
                op1   = 3'($urandom_range(0, 7));
                a1    = $urandom;
                b1    = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 40));
            end
            applyStimulus({pend1, pend0}, op0, a0, b0, op1, a1, b1, 2'($urandom_range(0, 3)));
            reset = ($urandom_range(0, 150) == 0);
        end
        reset = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
